armleocpu_operand_fetch: RTL and testbench

Operand-fetch stage that sits directly downstream of two register-file read lanes (one per source operand) and upstream of execute. It accepts source register numbers from decode with a valid/ready handshake, issues the one-cycle-latency register-file reads, and presents both operands to execute in a single registered output slot. It forwards same-cycle and later writeback data so that execute never sees a stale register value. Register x0 always reads as zero.

---
 rtl/armleocpu_operand_fetch.sv | 128 ++++++++++++
 tb/tb_armleocpu_operand_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_operand_fetch.sv
// Operand-fetch slot between two register-file read lanes and execute.
// Writeback forwarding is compiled in when ARMLEOCPU_OPFETCH_BYPASS_EN is defined.
module armleocpu_operand_fetch #(
    parameter int ELEMENTS_W = 5,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [ELEMENTS_W-1:0] d_rs1,
    input  logic [ELEMENTS_W-1:0] d_rs2,

    output logic                  rf_rs1_read,
    output logic [ELEMENTS_W-1:0] rf_rs1_address,
    input  logic [WIDTH-1:0]      rf_rs1_readdata,
    output logic                  rf_rs2_read,
    output logic [ELEMENTS_W-1:0] rf_rs2_address,
    input  logic [WIDTH-1:0]      rf_rs2_readdata,

    input  logic                  wb_write,
    input  logic [ELEMENTS_W-1:0] wb_address,
    input  logic [WIDTH-1:0]      wb_data,

    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [WIDTH-1:0]      o_rs1_data,
    output logic [WIDTH-1:0]      o_rs2_data
);

    logic                  o_valid_q;
    logic [ELEMENTS_W-1:0] rs1_addr_q;
    logic [ELEMENTS_W-1:0] rs2_addr_q;
    logic                  accept_s;

    // x0 reads as zero, then forwarded data, then the lane output
    function automatic logic [WIDTH-1:0] select_operand(
        input logic [ELEMENTS_W-1:0] addr,
        input logic                  byp_flag,
        input logic [WIDTH-1:0]      byp_data,
        input logic [WIDTH-1:0]      lane_data
    );
        logic [WIDTH-1:0] res;
        if (addr == {ELEMENTS_W{1'b0}}) begin
            res = {WIDTH{1'b0}};
        end else if (byp_flag) begin
            res = byp_data;
        end else begin
            res = lane_data;
        end
        return res;
    endfunction

    assign d_ready        = !o_valid_q || o_ready;
    assign accept_s       = d_valid && d_ready;
    assign rf_rs1_read    = accept_s;
    assign rf_rs2_read    = accept_s;
    assign rf_rs1_address = d_rs1;
    assign rf_rs2_address = d_rs2;
    assign o_valid        = o_valid_q;

    // Output slot: latch source numbers on accept, drop valid on a bare consume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid_q  <= 1'b0;
            rs1_addr_q <= {ELEMENTS_W{1'b0}};
            rs2_addr_q <= {ELEMENTS_W{1'b0}};
        end else if (accept_s) begin
            o_valid_q  <= 1'b1;
            rs1_addr_q <= d_rs1;
            rs2_addr_q <= d_rs2;
        end else if (o_ready) begin
            o_valid_q  <= 1'b0;
        end
    end

`ifdef ARMLEOCPU_OPFETCH_BYPASS_EN
    logic             rs1_byp_q;
    logic             rs2_byp_q;
    logic [WIDTH-1:0] rs1_byp_data_q;
    logic [WIDTH-1:0] rs2_byp_data_q;
    logic             holding_s;

    function automatic logic wb_hits(input logic [ELEMENTS_W-1:0] addr);
        return wb_write && (wb_address == addr) && (addr != {ELEMENTS_W{1'b0}});
    endfunction

    // A write during the consume cycle is dropped: the slot is emptying
    assign holding_s = o_valid_q && !o_ready;

    // Forwarding capture: accept-cycle write covers read-during-write, later writes while holding overwrite
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_byp_q      <= 1'b0;
            rs2_byp_q      <= 1'b0;
            rs1_byp_data_q <= {WIDTH{1'b0}};
            rs2_byp_data_q <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            rs1_byp_q      <= wb_hits(d_rs1);
            rs2_byp_q      <= wb_hits(d_rs2);
            rs1_byp_data_q <= wb_data;
            rs2_byp_data_q <= wb_data;
        end else if (holding_s) begin
            if (wb_hits(rs1_addr_q)) begin
                rs1_byp_q      <= 1'b1;
                rs1_byp_data_q <= wb_data;
            end
            if (wb_hits(rs2_addr_q)) begin
                rs2_byp_q      <= 1'b1;
                rs2_byp_data_q <= wb_data;
            end
        end
    end

    assign o_rs1_data = select_operand(rs1_addr_q, rs1_byp_q, rs1_byp_data_q, rf_rs1_readdata);
    assign o_rs2_data = select_operand(rs2_addr_q, rs2_byp_q, rs2_byp_data_q, rf_rs2_readdata);
`else
    logic unused_wb_s;

    // Without forwarding decode/issue must avoid hazards; writeback is not observed here
    assign unused_wb_s = ^{wb_write, wb_address, wb_data};

    assign o_rs1_data = select_operand(rs1_addr_q, 1'b0, {WIDTH{1'b0}}, rf_rs1_readdata);
    assign o_rs2_data = select_operand(rs2_addr_q, 1'b0, {WIDTH{1'b0}}, rf_rs2_readdata);
`endif

endmodule

// File: tb/tb_armleocpu_operand_fetch.sv
// Scoreboard bench for armleocpu_operand_fetch: behavioural lanes plus an architectural register model.
module tb_armleocpu_operand_fetch;
    localparam int EW = 5;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_valid, d_ready;
    logic [EW-1:0] d_rs1, d_rs2;
    logic          rf_rs1_read, rf_rs2_read;
    logic [EW-1:0] rf_rs1_address, rf_rs2_address;
    logic [W-1:0]  rf_rs1_readdata = 32'h0;
    logic [W-1:0]  rf_rs2_readdata = 32'h0;
    logic          wb_write;
    logic [EW-1:0] wb_address;
    logic [W-1:0]  wb_data;
    logic          o_valid, o_ready;
    logic [W-1:0]  o_rs1_data, o_rs2_data;

    int tests = 0;
    int fails = 0;
    int beats = 0;

    typedef struct {
        logic [EW-1:0] rs1;
        logic [EW-1:0] rs2;
        logic [W-1:0]  v1;
        logic [W-1:0]  v2;
    } req_t;
    req_t sb_q[$];

    logic [W-1:0] lane_mem [32];
    logic [W-1:0] arch     [32];
    logic         prev_acc = 1'b0;

    always #5 clk = ~clk;

    armleocpu_operand_fetch #(.ELEMENTS_W(EW), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .d_valid(d_valid), .d_ready(d_ready), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .rf_rs1_read(rf_rs1_read), .rf_rs1_address(rf_rs1_address), .rf_rs1_readdata(rf_rs1_readdata),
        .rf_rs2_read(rf_rs2_read), .rf_rs2_address(rf_rs2_address), .rf_rs2_readdata(rf_rs2_readdata),
        .wb_write(wb_write), .wb_address(wb_address), .wb_data(wb_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Register-file lanes: one-cycle read latency, old data on read-during-write, output held
    always @(posedge clk) begin
        if (rf_rs1_read) rf_rs1_readdata <= lane_mem[rf_rs1_address];
        if (rf_rs2_read) rf_rs2_readdata <= lane_mem[rf_rs2_address];
        if (wb_write) lane_mem[wb_address] <= wb_data;
    end

    // Architectural register state: value committed by every completed writeback
    always @(posedge clk) begin
        if (wb_write) arch[wb_address] = wb_data;
    end

    function automatic logic [W-1:0] reg_value(input logic [EW-1:0] r);
        return (r == 5'd0) ? 32'h0 : arch[r];
    endfunction

    // Monitor: compare each consumed beat, then record any new accept
    always @(negedge clk) begin
        if (rst) begin
            prev_acc = 1'b0;
        end else begin
            req_t e;
            if (prev_acc && !o_valid) check("latency", {31'h0, o_valid}, 32'h1);
            if (o_valid && o_ready) begin
                beats++;
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 32'h1, 32'h0);
                end else begin
                    e = sb_q.pop_front();
`ifdef ARMLEOCPU_OPFETCH_BYPASS_EN
                    check("rs1_data", o_rs1_data, reg_value(e.rs1));
                    check("rs2_data", o_rs2_data, reg_value(e.rs2));
`else
                    check("rs1_data", o_rs1_data, e.v1);
                    check("rs2_data", o_rs2_data, e.v2);
`endif
                end
            end
            prev_acc = d_valid && d_ready;
            if (prev_acc) begin
                e.rs1 = d_rs1;
                e.rs2 = d_rs2;
                e.v1  = reg_value(d_rs1);
                e.v2  = reg_value(d_rs2);
                sb_q.push_back(e);
            end
        end
    end

    task automatic step(input logic v, input logic [EW-1:0] a, input logic [EW-1:0] b,
                        input logic rdy, input logic ww, input logic [EW-1:0] wa,
                        input logic [W-1:0] wd, input logic chk_stall);
        d_valid = v; d_rs1 = a; d_rs2 = b; o_ready = rdy;
        wb_write = ww; wb_address = wa; wb_data = wd;
        @(negedge clk);
        if (chk_stall) check("d_ready_stall", {31'h0, d_ready}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0;
        for (int i = 0; i < 32; i++) begin
            lane_mem[i] = $urandom;
            arch[i]     = lane_mem[i];
        end
        lane_mem[0] = 32'hFFFF_FFFF; arch[0] = 32'hFFFF_FFFF;
        lane_mem[3] = 32'h11;        arch[3] = 32'h11;
        lane_mem[4] = 32'h22;        arch[4] = 32'h22;
        rst = 1'b1; d_valid = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0; o_ready = 1'b0;
        wb_write = 1'b0; wb_address = 5'd0; wb_data = 32'h0;
        #23;
        check("rst_o_valid", {31'h0, o_valid}, 32'h0);
        check("rst_rs1", o_rs1_data, 32'h0);
        check("rst_rs2", o_rs2_data, 32'h0);
        check("rst_d_ready", {31'h0, d_ready}, 32'h1);
        @(posedge clk); #1; rst = 1'b0;

        // Basic accept/consume, then x0 against a nonzero lane entry
        step(1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        check("t1_valid_clear", {31'h0, o_valid}, 32'h0);
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);

        // Read-during-write on accept
        step(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 32'hABCD, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);

        // Held slot sees successive writes; decode is stalled throughout
        step(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b1, 5'd8, 5'd9, 1'b0, 1'b1, 5'd7, 32'h1, 1'b1);
        step(1'b1, 5'd8, 5'd9, 1'b0, 1'b1, 5'd7, 32'h2, 1'b1);
        step(1'b1, 5'd8, 5'd9, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);

        // Streaming: eight back-to-back beats
        b0 = beats;
        for (int i = 0; i < 8; i++)
            step(1'b1, 5'(i + 8), 5'(i + 16), 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        check("stream_beats", 32'(beats - b0), 32'd8);

        // Randomised traffic with hazards concentrated on a few registers
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 ($urandom % 3) != 0, ($urandom % 2) != 0, 5'($urandom_range(0, 7)),
                 $urandom, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset while a slot is held
        step(1'b1, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        check("pre_rst_valid", {31'h0, o_valid}, 32'h1);
        #2; rst = 1'b1; #1;
        sb_q.delete();
        check("arst_o_valid", {31'h0, o_valid}, 32'h0);
        check("arst_rs1", o_rs1_data, 32'h0);
        check("arst_rs2", o_rs2_data, 32'h0);
        @(posedge clk); #1; rst = 1'b0; #1;
        check("arst_d_ready", {31'h0, d_ready}, 32'h1);
        step(1'b1, 5'd4, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        check("final_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
